// File: rtl/tx_byte_queue.sv
// Queues controller response bytes and presents each one to the TX data synchronizer, held for HOLD_CYCLES, then follows the TX_Busy_SYNC handshake.
// Latency: byte written at edge k is presented after edge k+1; overflowed writes are dropped and flagged with DROP.
module tx_byte_queue #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [DATA_WIDTH-1:0]      IN_DATA,
    input  logic                       IN_VALID,
    input  logic                       TX_Busy_SYNC,
    output logic [DATA_WIDTH-1:0]      OUT_DATA,
    output logic                       OUT_VALID,
    output logic                       FULL,
    output logic                       EMPTY,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       DROP,
    output logic                       TIMEOUT_ERR
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  drop_q, terr_q, terr_d;
    logic                  full, empty, push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // FULL is taken from the registered count, so a same-cycle pop never rescues a write
    assign push  = IN_VALID && !full;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= IN_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_data_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            drop_q <= IN_VALID && full;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + AW'(1);
                out_data_q <= mem_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && !TX_Busy_SYNC) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (cnt_q == 8'(HOLD_CYCLES - 1)) begin
                    state_d = S_WAIT_BUSY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT_BUSY: begin
                if (TX_Busy_SYNC) begin
                    state_d = S_WAIT_DONE;
                    cnt_d   = '0;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    // transmitter never picked the byte up; it is abandoned
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!TX_Busy_SYNC) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pop       = (state_q == S_IDLE) && !empty && !TX_Busy_SYNC;
        OUT_VALID = (state_q == S_HOLD);
    end

    assign OUT_DATA    = out_data_q;
    assign FULL        = full;
    assign EMPTY       = empty;
    assign COUNT       = count_q;
    assign DROP        = drop_q;
    assign TIMEOUT_ERR = terr_q;
endmodule

// File: tb/tb_tx_byte_queue.sv
module tb_tx_byte_queue;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int HOLD  = 16;
    localparam int TO    = 255;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK, RST;
    logic [DW-1:0] IN_DATA;
    logic          IN_VALID;
    logic          TX_Busy_SYNC;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_VALID, FULL, EMPTY, DROP, TIMEOUT_ERR;
    logic [CW-1:0] COUNT;

    logic auto_tx, tx_auto, man_busy;
    assign TX_Busy_SYNC = auto_tx ? tx_auto : man_busy;

    tx_byte_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .TX_Busy_SYNC(TX_Busy_SYNC), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
        .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .DROP(DROP), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a byte queue plus the presentation phase with down-counting timers
    logic [DW-1:0] mq[$];
    int            ph;          // 0 idle, 1 presenting, 2 awaiting busy, 3 awaiting not-busy
    int            hold_left, wait_left;
    logic [DW-1:0] m_data;
    logic          m_drop, m_terr;

    task automatic m_reset();
        mq.delete();
        ph = 0; hold_left = 0; wait_left = 0;
        m_data = '0; m_drop = 1'b0; m_terr = 1'b0;
    endtask

    task automatic m_step(input logic vld, input logic [DW-1:0] din, input logic busy);
        bit full_now, do_pop;
        full_now = (mq.size() == DEPTH);
        do_pop   = (ph == 0) && (mq.size() != 0) && !busy;
        m_drop   = vld && full_now;
        m_terr   = 1'b0;
        case (ph)
            0: if (do_pop) begin ph = 1; hold_left = HOLD; end
            1: if (hold_left == 1) begin ph = 2; wait_left = TO; end else hold_left--;
            2: if (busy) ph = 3;
               else if (wait_left == 1) begin m_terr = 1'b1; ph = 0; end
               else wait_left--;
            default: if (!busy) ph = 0;
        endcase
        if (do_pop) m_data = mq.pop_front();
        if (vld && !full_now) mq.push_back(din);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) m_reset();
            else m_step(IN_VALID, IN_DATA, TX_Busy_SYNC);
        end
    end

    logic cmp_en = 1'b0;
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST && cmp_en) begin
                chk("OUT_VALID", OUT_VALID, (ph == 1));
                chk("OUT_DATA", OUT_DATA, m_data);
                chk("COUNT", COUNT, mq.size());
                chk("FULL", FULL, (mq.size() == DEPTH));
                chk("EMPTY", EMPTY, (mq.size() == 0));
                chk("DROP", DROP, m_drop);
                chk("TIMEOUT_ERR", TIMEOUT_ERR, m_terr);
            end
        end
    end

    // Output log of presented bytes, taken on each OUT_VALID rise
    logic [DW-1:0] out_log[$];
    int   rises = 0, ff_seen = 0;
    logic prev_v = 1'b0;
    initial begin
        forever begin
            @(negedge CLK);
            if (OUT_VALID && !prev_v) begin
                rises++;
                out_log.push_back(OUT_DATA);
                if (OUT_DATA == 8'hFF) ff_seen++;
            end
            prev_v = OUT_VALID;
        end
    end

    // Randomised transmitter: goes busy some cycles after a byte is offered, then idles again
    initial begin
        tx_auto = 1'b0;
        forever begin
            @(negedge CLK);
            if (auto_tx && OUT_VALID) begin
                repeat ($urandom_range(0, 20)) @(negedge CLK);
                tx_auto = 1'b1;
                repeat ($urandom_range(1, 12)) @(negedge CLK);
                tx_auto = 1'b0;
            end
        end
    end

    task automatic wr1(input logic [DW-1:0] d);
        @(negedge CLK);
        IN_VALID = 1'b1; IN_DATA = d;
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic wait_valid(input logic lvl, input string name);
        int n = 0;
        while (OUT_VALID !== lvl && n < 1000) begin
            @(posedge CLK); #1; n++;
        end
        chk(name, OUT_VALID, lvl);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(ph == 0 && mq.size() == 0) && n < 3000) begin
            @(negedge CLK); n++;
        end
        chk("drain_bound", (ph == 0 && mq.size() == 0), 1);
    endtask

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; IN_DATA = '0; man_busy = 1'b0; auto_tx = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_OUT_VALID", OUT_VALID, 0);
        chk("rst_OUT_DATA", OUT_DATA, 0);
        chk("rst_FULL", FULL, 0);
        chk("rst_EMPTY", EMPTY, 1);
        chk("rst_COUNT", COUNT, 0);
        chk("rst_DROP", DROP, 0);
        chk("rst_TIMEOUT_ERR", TIMEOUT_ERR, 0);
        RST = 1'b0;
        cmp_en = 1'b1;
        repeat (5) @(negedge CLK);

        // single byte: latency and hold width
        IN_VALID = 1'b1; IN_DATA = 8'hA5;
        @(posedge CLK); #1;
        chk("t1_empty_after_write", EMPTY, 0);
        chk("t1_no_valid_yet", OUT_VALID, 0);
        @(negedge CLK); IN_VALID = 1'b0;
        @(posedge CLK); #1;
        chk("t1_valid_rise", OUT_VALID, 1);
        chk("t1_data", OUT_DATA, 8'hA5);
        repeat (HOLD - 1) @(posedge CLK);
        #1 chk("t1_valid_last_cycle", OUT_VALID, 1);
        @(posedge CLK); #1;
        chk("t1_valid_fall", OUT_VALID, 0);
        chk("t1_data_retained", OUT_DATA, 8'hA5);
        repeat (5) @(negedge CLK);
        man_busy = 1'b1;
        repeat (100) @(negedge CLK);
        man_busy = 1'b0;
        repeat (3) @(negedge CLK);
        chk("t1_empty_end", EMPTY, 1);
        chk("t1_model_idle", ph, 0);

        // burst to full while transmitter busy, then overflow
        man_busy = 1'b1;
        out_log.delete(); ff_seen = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            IN_VALID = 1'b1; IN_DATA = 8'(i);
        end
        @(negedge CLK);
        chk("burst_full", FULL, 1);
        chk("burst_count", COUNT, 8);
        IN_DATA = 8'hFF;
        @(posedge CLK); #1;
        chk("ovf_drop", DROP, 1);
        chk("ovf_count", COUNT, 8);
        @(negedge CLK); IN_VALID = 1'b0;
        @(posedge CLK); #1;
        chk("ovf_drop_width", DROP, 0);
        man_busy = 1'b0;
        auto_tx  = 1'b1;
        wait_idle();
        repeat (300) @(negedge CLK);
        wait_idle();
        chk("burst_n_out", out_log.size(), 8);
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            chk("burst_order", out_log[i], i + 1);
        chk("ovf_never_out", ff_seen, 0);

        // timeout with no busy, then the next byte is presented normally
        auto_tx = 1'b0; man_busy = 1'b0;
        repeat (40) @(negedge CLK);
        wait_idle();
        wr1(8'h3C);
        wr1(8'h5A);
        wait_valid(1'b1, "to_rise");
        wait_valid(1'b0, "to_fall");
        begin
            int n = 0;
            while (TIMEOUT_ERR !== 1'b1 && n < 400) begin
                @(posedge CLK); #1; n++;
            end
            chk("to_distance", n, TO);
        end
        wait_valid(1'b1, "to_next_rise");
        chk("to_next_data", OUT_DATA, 8'h5A);
        wait_valid(1'b0, "to_next_fall");
        @(negedge CLK); man_busy = 1'b1;
        repeat (10) @(negedge CLK); man_busy = 1'b0;
        wait_idle();

        // randomised traffic across pointer wrap, light then heavy load
        auto_tx = 1'b1;
        for (int ph_i = 0; ph_i < 2; ph_i++) begin
            for (int c = 0; c < 2500; c++) begin
                @(negedge CLK);
                IN_VALID = (ph_i == 0) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 3) == 0);
                IN_DATA  = 8'($urandom_range(0, 254));
            end
        end
        @(negedge CLK); IN_VALID = 1'b0;

        // reset while presenting with bytes queued
        auto_tx = 1'b0; man_busy = 1'b0;
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            IN_VALID = 1'b1; IN_DATA = 8'(8'h10 + i);
        end
        @(negedge CLK); IN_VALID = 1'b0;
        wait_valid(1'b1, "mid_rise");
        @(negedge CLK);
        chk("mid_count_before", COUNT, 3);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_valid", OUT_VALID, 0);
        chk("mid_rst_data", OUT_DATA, 0);
        chk("mid_rst_count", COUNT, 0);
        chk("mid_rst_empty", EMPTY, 1);
        @(negedge CLK); #2 RST = 1'b0;
        rises = 0;
        repeat (40) @(negedge CLK);
        chk("mid_no_output", rises, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/tx_byte_queue.md
# tx_byte_queue

Buffers response bytes produced by the system controller in the REF_CLK domain and presents them one at a time to the TX-side data synchronizer, which feeds the UART transmitter. Each byte is held stable with its enable level for a programmable number of cycles so the slower TX clock domain can capture it. The block then tracks the synchronized TX_Busy handshake before releasing the next byte. It replaces ad-hoc counter logic at the controller/synchronizer boundary and prevents back-to-back controller responses from being lost.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width
- DEPTH, 8, FIFO entries (power of 2, ≥2)
- HOLD_CYCLES, 16, cycles OUT_VALID is held per byte (≥1, ≤255)
- TIMEOUT, 255, max cycles waiting for TX_Busy_SYNC rise (≥1, ≤255)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high. The clock is named CLK and the reset is named RST.
- CLK  in  1  REF_CLK domain clock
- RST  in  1  asynchronous, active-high reset
- IN_DATA  in  DATA_WIDTH  byte from controller (TX_P_DATA)
- IN_VALID  in  1  single-cycle write strobe (TX_DATA_VALID)
- TX_Busy_SYNC  in  1  transmitter busy, already synchronized to CLK
- OUT_DATA  out  DATA_WIDTH  byte to data synchronizer Unsync_bus
- OUT_VALID  out  1  level enable to data synchronizer bus_enable
- FULL  out  1  COUNT == DEPTH
- EMPTY  out  1  COUNT == 0
- COUNT  out  $clog2(DEPTH)+1  stored entries
- DROP  out  1  one-cycle pulse: write rejected
- TIMEOUT_ERR  out  1  one-cycle pulse: transmitter never went busy

## Operation
- FIFO: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits, which wrap modulo DEPTH, plus a registered COUNT. FULL and EMPTY are decoded from the registered COUNT.
- Push: IN_VALID && !FULL writes IN_DATA at wr_ptr.
- Overflow: IN_VALID && FULL discards the byte and pulses DROP the following cycle. This holds even when a pop occurs in the same cycle, because FULL is evaluated from the current registered COUNT.
- Simultaneous push and pop (not full): COUNT is unchanged and both pointers advance.
- FSM states: IDLE, HOLD, WAIT_BUSY, WAIT_DONE.
  - IDLE: if !EMPTY && !TX_Busy_SYNC, pop the head into the OUT_DATA register, set OUT_VALID=1, clear the counter, and go to HOLD. Otherwise stay in IDLE.
  - HOLD: OUT_VALID=1 and OUT_DATA is stable. The counter increments each cycle. When it reaches HOLD_CYCLES-1, clear OUT_VALID, clear the counter, and go to WAIT_BUSY.
  - WAIT_BUSY: if TX_Busy_SYNC=1, go to WAIT_DONE. Else, if the counter reaches TIMEOUT-1, pulse TIMEOUT_ERR and go to IDLE; the byte is considered lost. Else increment the counter.
  - WAIT_DONE: if TX_Busy_SYNC=0, go to IDLE.
- OUT_DATA retains the last byte after OUT_VALID falls and changes only on a pop.
- Counter width is 8 bits and never wraps; it is cleared on every state entry.

## Timing
- Reset values: OUT_DATA=0, OUT_VALID=0, FULL=0, EMPTY=1, COUNT=0, DROP=0, TIMEOUT_ERR=0, state IDLE, both pointers 0.
- RST asserted mid-operation immediately clears all of the above and empties the FIFO. Any byte in flight is abandoned.
- First-byte latency: a write sampled at edge k updates EMPTY after edge k. The pop occurs at edge k+1, so OUT_VALID=1 and OUT_DATA is valid after edge k+1.
- OUT_VALID is high for exactly HOLD_CYCLES cycles and falls after edge k+1+HOLD_CYCLES.
- The next pop occurs no earlier than 2 edges after TX_Busy_SYNC is sampled low in WAIT_DONE: one edge to return to IDLE, one to pop.
- If TX_Busy_SYNC is high while in IDLE, the pop is withheld until it falls.
- DROP and TIMEOUT_ERR are each exactly one cycle wide and registered.
- COUNT, FULL, and EMPTY update on the edge after the push or pop.

## Test plan
- Reset then single byte: write 0xA5 at edge 10 → OUT_VALID rises after edge 11, OUT_DATA=0xA5, stays high 16 cycles. Drive busy high 5 cycles later, low 100 cycles later → FSM returns to IDLE, EMPTY=1.
- Burst of 8 writes 0x01..0x08 on consecutive cycles → FULL=1 and COUNT=8 after the 8th. Each byte is presented in order, each only after the previous busy low phase.
- Overflow: with FIFO full, write 0xFF → DROP pulses for 1 cycle, COUNT stays 8, and 0xFF is never output.
- Timeout: write 0x3C and hold TX_Busy_SYNC low → TIMEOUT_ERR pulses 255 cycles after OUT_VALID falls. The next queued byte is then presented normally.
- Wrap-around and simultaneous push/pop: push 12 bytes interleaved with pops across pointer wrap. Verify output order matches input order and COUNT is unchanged on push+pop cycles.
- Reset mid-HOLD with 3 bytes queued → OUT_VALID=0, OUT_DATA=0, COUNT=0, and EMPTY=1 immediately. No further output without new writes.
